// File: rtl/rand_note_scheduler.sv
// Draws a random byte from the LFSR, splits it into lane and gap, waits the gap on tick, then offers the note.
// Optional feature macro: NO_REPEAT_LANE_EN (bump a lane that repeats the previously accepted one).
module rand_note_scheduler #(
    parameter int MIN_GAP = 4,
    parameter int GAP_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic [7:0]       rand_in,
    output logic             rand_en,
    output logic             note_valid,
    output logic [1:0]       note_lane,
    input  logic             note_ready,
    output logic             busy,
    output logic [CNT_W-1:0] note_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DRAW    = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] PRESENT = 3'd4;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_load;
    logic             stop_pend;
    logic             accept;
    logic [1:0]       lane_pick;
    logic [1:0]       unused_rand;

    // Bits [3:2] of the random byte carry no meaning for this stage.
    assign unused_rand = rand_in[3:2];

    assign note_valid = (state == PRESENT);
    assign busy       = (state != IDLE);
    assign accept     = note_valid && note_ready;
    assign gap_load   = GAP_W'(MIN_GAP) + GAP_W'(rand_in[7:4]);

`ifdef NO_REPEAT_LANE_EN
    logic [1:0] prev_lane;

    assign lane_pick = (rand_in[1:0] == prev_lane) ? rand_in[1:0] + 2'd1 : rand_in[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_lane <= 2'd0;
        end else if (accept) begin
            prev_lane <= note_lane;
        end
    end
`else
    assign lane_pick = rand_in[1:0];
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    next_state = DRAW;
                end
            end
            DRAW: begin
                next_state = stop ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                next_state = stop ? IDLE : WAIT;
            end
            WAIT: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (gap_cnt == '0) begin
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                // A stop arriving together with the handshake still ends generation.
                if (note_ready) begin
                    next_state = (stop_pend || stop) ? IDLE : DRAW;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rand_en   <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state   <= next_state;
            rand_en <= (next_state == DRAW);
            if (next_state == IDLE) begin
                stop_pend <= 1'b0;
            end else if (state == PRESENT && stop) begin
                stop_pend <= 1'b1;
            end
        end
    end

    // The counter is checked for zero before any tick is honoured, so a tick at zero is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt   <= '0;
            note_lane <= 2'd0;
        end else if (state == CAPTURE) begin
            gap_cnt   <= gap_load;
            note_lane <= lane_pick;
        end else if (state == WAIT && tick && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            note_count <= '0;
        end else if (accept) begin
            note_count <= note_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rand_note_scheduler.sv
// Scoreboard bench: expected lanes are queued when the LFSR advances and compared at each accepted handshake.
module tb_rand_note_scheduler;

`ifdef NO_REPEAT_LANE_EN
    localparam bit NRL = 1'b1;
`else
    localparam bit NRL = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        tick;
    logic [7:0]  rand_in;
    logic        rand_en;
    logic        note_valid;
    logic [1:0]  note_lane;
    logic        note_ready;
    logic        busy;
    logic [15:0] note_count;

    int          checks;
    int          failures;
    int          cyc;
    int          model_count;
    logic [1:0]  model_prev;
    logic [7:0]  rand_q[$];
    logic [1:0]  exp_q[$];

    rand_note_scheduler #(.MIN_GAP(4), .GAP_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .rand_in    (rand_in),
        .rand_en    (rand_en),
        .note_valid (note_valid),
        .note_lane  (note_lane),
        .note_ready (note_ready),
        .busy       (busy),
        .note_count (note_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] lane_of(input logic [7:0] r);
        if (NRL && r[1:0] == model_prev) return r[1:0] + 2'd1;
        return r[1:0];
    endfunction

    // One clock: handshake and LFSR advance are judged on pre-edge values, outputs sampled 1 ns after the edge.
    task automatic step();
        logic       hs;
        logic       re;
        logic [1:0] lane_pre;
        logic [7:0] r;
        hs       = note_valid && note_ready;
        re       = rand_en;
        lane_pre = note_lane;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            model_count++;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("sb_lane", 32'(lane_pre), 32'(exp_q.pop_front()));
            end
            chk("sb_count", 32'(note_count), 32'(model_count[15:0]));
            model_prev = lane_pre;
        end
        if (re) begin
            r = (rand_q.size() != 0) ? rand_q.pop_front() : 8'($urandom);
            rand_in = r;
            exp_q.push_back(lane_of(r));
        end
    endtask

    task automatic wait_valid(input string tag, input int limit, output int n);
        n = 0;
        while (!note_valid && n < limit) begin
            step();
            n++;
        end
        if (!note_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int ticks;
        int last_k;
        int brk_k;
        bit any;
        checks = 0; failures = 0; cyc = 0; model_count = 0; model_prev = 2'd0;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        note_ready = 1'b0; rand_in = 8'hA7;

        // Reset state
        #12;
        chk("rst_rand_en", 32'(rand_en), 32'd0);
        chk("rst_valid", 32'(note_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lane", 32'(note_lane), 32'd0);
        chk("rst_count", 32'(note_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: start, draw 0x55 -> lane 1, gap 9
        rand_q.push_back(8'h55);
        tick = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        chk("t1_rand_en_draw", 32'(rand_en), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_rand_en_one_clk", 32'(rand_en), 32'd0);
        wait_valid("t1", 100, n);
        // CAPTURE -> WAIT, 9 decrements, one cycle observing zero, then PRESENT
        chk("t1_latency", 32'(n), 32'd11);
        chk("t1_lane", 32'(note_lane), 32'd1);

        // 2: backpressure for 20 clks
        rand_q.push_back(8'h00);
        any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!note_valid || note_lane != 2'd1 || rand_en) any = 1'b1;
        end
        chk("t2_stable", 32'(any), 32'd0);
        note_ready = 1'b1; step(); note_ready = 1'b0;
        chk("t2_count", 32'(note_count), 32'd1);
        chk("t2_next_rand_en", 32'(rand_en), 32'd1);

        // 3: tick every third clock, gap 4
        tick = 1'b0;
        step();
        step();
        ticks = 0; last_k = -10; brk_k = -1;
        for (int k = 0; k < 60; k++) begin
            tick = (k % 3 == 2);
            if (tick) begin
                ticks++;
                last_k = k;
            end
            step();
            if (note_valid) begin
                brk_k = k;
                break;
            end
        end
        chk("t3_ticks", 32'(ticks), 32'd4);
        chk("t3_rise", 32'(brk_k), 32'(last_k + 1));
        chk("t3_lane", 32'(note_lane), 32'(lane_of(8'h00)));
        tick = 1'b1;
        rand_q.push_back(8'hF0);
        note_ready = 1'b1; step(); note_ready = 1'b0;
        chk("t3_count", 32'(note_count), 32'd2);

        // 4a: stop in WAIT discards the note
        step(); step(); step(); step(); step();
        stop = 1'b1; step(); stop = 1'b0;
        exp_q.delete();
        chk("t4a_busy", 32'(busy), 32'd0);
        chk("t4a_valid", 32'(note_valid), 32'd0);
        chk("t4a_count", 32'(note_count), 32'd2);
        any = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (note_valid || rand_en || busy) any = 1'b1;
        end
        chk("t4a_quiet", 32'(any), 32'd0);

        // 4c: start and stop together from IDLE
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("t4c_busy", 32'(busy), 32'd0);
        chk("t4c_rand_en", 32'(rand_en), 32'd0);

        // 4b: stop while presenting, note kept until accepted
        rand_q.push_back(8'h02);
        start = 1'b1; step(); start = 1'b0;
        wait_valid("t4b", 50, n);
        chk("t4b_lane", 32'(note_lane), 32'(lane_of(8'h02)));
        stop = 1'b1; step(); stop = 1'b0;
        chk("t4b_held", 32'(note_valid), 32'd1);
        step(); step(); step();
        chk("t4b_held_late", 32'(note_valid), 32'd1);
        note_ready = 1'b1; step(); note_ready = 1'b0;
        chk("t4b_idle", 32'(busy), 32'd0);
        chk("t4b_count", 32'(note_count), 32'd3);
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rand_en) any = 1'b1;
        end
        chk("t4b_no_rand_en", 32'(any), 32'd0);

        // 6: repeated lanes, 2 after 2 and 3 after 3
        rand_q.push_back(8'h02);
        rand_q.push_back(8'h03);
        note_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        wait_valid("t6a", 50, n);
        chk("t6_lane_2_again", 32'(note_lane), NRL ? 32'd3 : 32'd2);
        step();
        wait_valid("t6b", 50, n);
        chk("t6_lane_3_again", 32'(note_lane), NRL ? 32'd0 : 32'd3);
        stop = 1'b1; step(); stop = 1'b0;
        note_ready = 1'b0;
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_count", 32'(note_count), 32'd5);

        // 5: asynchronous reset between edges while waiting
        rand_q.push_back(8'h13);
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step(); step();
        chk("t5_pre_lane", 32'(note_lane), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(note_valid), 32'd0);
        chk("t5_rand_en", 32'(rand_en), 32'd0);
        chk("t5_lane", 32'(note_lane), 32'd0);
        chk("t5_count", 32'(note_count), 32'd0);
        exp_q.delete();
        model_count = 0;
        model_prev = 2'd0;
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_after_busy", 32'(busy), 32'd0);

        // Fresh note after reset
        rand_q.push_back(8'h21);
        note_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        wait_valid("t7", 50, n);
        stop = 1'b1; step(); stop = 1'b0;
        note_ready = 1'b0;
        chk("t7_count", 32'(note_count), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
